// File: rtl/popcount_chunk_scheduler.sv
// ============================================================================
// Module   : popcount_chunk_scheduler
// Brief    : Counts the set bits of a wide word with one narrow popcount stage,
//            one chunk per cycle. Optional macro: POPCNT_SCHED_ZERO_SKIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_chunk_scheduler #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 16,
    parameter int STAT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    srst_ni,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [$clog2(DATA_W):0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic [STAT_W-1:0]       words_o
);

    localparam int c_nchunk  = DATA_W / CHUNK_W;
    localparam int c_k_w     = $clog2(c_nchunk);
    localparam int c_acc_w   = $clog2(DATA_W) + 1;
    localparam int c_stage_w = $clog2(CHUNK_W) + 1;
    localparam logic [c_k_w-1:0] c_k_last = c_k_w'(c_nchunk - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_W-1:0]     r_shift;
    logic [c_k_w-1:0]      r_k;
    logic [c_stage_w-1:0]  r_stage_q;
    logic                  r_stage_vld;
    logic [c_acc_w-1:0]    r_acc;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_busy;
    logic [STAT_W-1:0]     r_words;

    logic [c_stage_w-1:0]  w_chunk_pop;
    logic [DATA_W-1:0]     w_shift_next;
    logic                  w_last_issue;
    logic                  w_zero_word;

    always_comb begin
        w_chunk_pop = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            w_chunk_pop = w_chunk_pop + c_stage_w'(r_shift[i]);
        end
    end

    assign w_shift_next = r_shift >> CHUNK_W;

`ifdef POPCNT_SCHED_ZERO_SKIP_EN
    // Stop issuing once the remaining chunks are all zero; a zero word skips RUN.
    assign w_last_issue = (r_k == c_k_last) || (w_shift_next == '0);
    assign w_zero_word  = (data_i == '0);
`else
    assign w_last_issue = (r_k == c_k_last);
    assign w_zero_word  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_k         <= '0;
            r_stage_q   <= '0;
            r_stage_vld <= 1'b0;
            r_acc       <= '0;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_words     <= '0;
        end else begin
            // The stage result lands one cycle after its chunk is issued.
            if (r_stage_vld) begin
                r_acc <= r_acc + c_acc_w'(r_stage_q);
            end

            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (r_ready && valid_i) begin
                        r_shift     <= data_i;
                        r_acc       <= '0;
                        r_k         <= '0;
                        r_stage_vld <= 1'b0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= w_zero_word ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    r_stage_q   <= w_chunk_pop;
                    r_stage_vld <= 1'b1;
                    r_shift     <= w_shift_next;
                    r_k         <= r_k + 1'b1;
                    if (w_last_issue) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_stage_vld <= 1'b0;
                    r_valid     <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_words <= r_words + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign data_o  = r_acc;
    assign words_o = r_words;

endmodule

`default_nettype wire
